// File: rtl/nv_fifo_ctrl_pkg.sv
// Shared sizing for the 4x128 FIFO controller and its RAM: depth, widths, count type.
package nv_fifo_ctrl_pkg;
   localparam int NV_FIFO_DEPTH = 4;
   localparam int NV_FIFO_AW    = 2;
   localparam int NV_FIFO_DW    = 128;

   // Occupancy counts span 0..5, so three bits are enough.
   typedef logic [2:0] nv_fifo_cnt_t;
endpackage

// File: rtl/nv_fifo_rd_pipe.sv
// Tracks the two RAM read stages (address register, output register) and gates re/ore.
// A stage holds while downstream stalls; ore only fires into an empty or popping output stage.
module nv_fifo_rd_pipe
   import nv_fifo_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic unrd_nz,
   input  logic rd_prdy,
   output logic ram_re,
   output logic ram_ore,
   output logic rd_pvld
);
   logic s1_vld;
   logic s2_vld;
   logic pop;

   assign pop     = s2_vld && rd_prdy;
   assign ram_ore = !rst && s1_vld && (!s2_vld || pop);
   assign ram_re  = !rst && unrd_nz && (!s1_vld || ram_ore);
   assign rd_pvld = s2_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
      end else begin
         s1_vld <= ram_re || (s1_vld && !ram_ore);
         s2_vld <= ram_ore || (s2_vld && !pop);
      end
   end
endmodule

// File: rtl/nv_ram_rwsp_4x128.sv
// 4x128 two-port RAM: write in 1 cycle; the read address is registered on re and the output on ore.
// There is no flow control here. The controller decides when re and ore fire.
module nv_ram_rwsp_4x128
   import nv_fifo_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  we,
   input  logic [NV_FIFO_AW-1:0] wa,
   input  logic [NV_FIFO_DW-1:0] di,
   input  logic                  re,
   input  logic [NV_FIFO_AW-1:0] ra,
   input  logic                  ore,
   output logic [NV_FIFO_DW-1:0] dout
);
   logic [NV_FIFO_DW-1:0] mem [NV_FIFO_DEPTH];
   logic [NV_FIFO_AW-1:0] ra_d;
   logic [NV_FIFO_DW-1:0] dout_r;

   always_ff @(posedge clk) begin
      if (we)  mem[wa] <= di;
      if (re)  ra_d    <= ra;
      if (ore) dout_r  <= mem[ra_d];
   end

   assign dout = dout_r;
endmodule

// File: rtl/nv_fifo_ctrl_4x128.sv
// 5-deep valid/ready FIFO over the 4x128 RAM; write-to-rd_pvld latency is 3 cycles. Backpressure holds the read pipe.
// Define NV_FIFO_CTRL_CNT_EN to add the registered fifo_cnt occupancy output.
module nv_fifo_ctrl_4x128
   import nv_fifo_ctrl_pkg::*;
#(
   parameter int DEPTH = NV_FIFO_DEPTH,
   parameter int AW    = NV_FIFO_AW,
   parameter int DW    = NV_FIFO_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_pvld,
   output logic          wr_prdy,
   input  logic [DW-1:0] wr_pd,
   output logic          rd_pvld,
   input  logic          rd_prdy,
   output logic [DW-1:0] rd_pd,
   output logic          ram_we,
   output logic [AW-1:0] ram_wa,
   output logic [DW-1:0] ram_di,
   output logic          ram_re,
   output logic [AW-1:0] ram_ra,
   output logic          ram_ore,
   input  logic [DW-1:0] ram_dout
`ifdef NV_FIFO_CTRL_CNT_EN
   ,
   output nv_fifo_cnt_t  fifo_cnt
`endif
);
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   nv_fifo_cnt_t  ram_cnt;
   nv_fifo_cnt_t  ram_cnt_nxt;
   nv_fifo_cnt_t  unrd_cnt;

   // A RAM slot is only freed once ore has captured it, so the write can never hit the slot ra_d is reading.
   assign wr_prdy = !rst && (ram_cnt != nv_fifo_cnt_t'(DEPTH));
   assign ram_we  = wr_pvld && wr_prdy;
   assign ram_wa  = wptr;
   assign ram_di  = wr_pd;
   assign ram_ra  = rptr;
   assign rd_pd   = ram_dout;

   assign ram_cnt_nxt = ram_cnt + nv_fifo_cnt_t'(ram_we) - nv_fifo_cnt_t'(ram_ore);

   nv_fifo_rd_pipe u_rd_pipe (
      .clk     (clk),
      .rst     (rst),
      .unrd_nz (unrd_cnt != '0),
      .rd_prdy (rd_prdy),
      .ram_re  (ram_re),
      .ram_ore (ram_ore),
      .rd_pvld (rd_pvld)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         ram_cnt  <= '0;
         unrd_cnt <= '0;
      end else begin
         if (ram_we) wptr <= wptr + 1'b1;
         if (ram_re) rptr <= rptr + 1'b1;
         ram_cnt  <= ram_cnt_nxt;
         unrd_cnt <= unrd_cnt + nv_fifo_cnt_t'(ram_we) - nv_fifo_cnt_t'(ram_re);
      end
   end

`ifdef NV_FIFO_CTRL_CNT_EN
   // Registered from next-state values so it always equals ram_cnt + s2_vld.
   logic s2_nxt;
   assign s2_nxt = ram_ore || (rd_pvld && !rd_prdy);

   always_ff @(posedge clk) begin
      if (rst) fifo_cnt <= '0;
      else     fifo_cnt <= ram_cnt_nxt + nv_fifo_cnt_t'(s2_nxt);
   end
`endif
endmodule

// File: tb/tb_nv_fifo_ctrl_4x128.sv
// Bench for nv_fifo_ctrl_4x128 + RAM: directed vectors plus an every-cycle check against a queue-based FIFO model.
module tb_nv_fifo_ctrl_4x128;
   import nv_fifo_ctrl_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         wr_pvld;
   logic         wr_prdy;
   logic [127:0] wr_pd;
   logic         rd_pvld;
   logic         rd_prdy;
   logic [127:0] rd_pd;
   logic         ram_we;
   logic [1:0]   ram_wa;
   logic [127:0] ram_di;
   logic         ram_re;
   logic [1:0]   ram_ra;
   logic         ram_ore;
   logic [127:0] ram_dout;
`ifdef NV_FIFO_CTRL_CNT_EN
   nv_fifo_cnt_t fifo_cnt;
`endif

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   nv_fifo_ctrl_4x128 dut (
      .clk(clk), .rst(rst),
      .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
      .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
      .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
      .ram_re(ram_re), .ram_ra(ram_ra), .ram_ore(ram_ore),
      .ram_dout(ram_dout)
`ifdef NV_FIFO_CTRL_CNT_EN
      , .fifo_cnt(fifo_cnt)
`endif
   );

   nv_ram_rwsp_4x128 u_ram (
      .clk(clk), .we(ram_we), .wa(ram_wa), .di(ram_di),
      .re(ram_re), .ra(ram_ra), .ore(ram_ore), .dout(ram_dout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Model: words leave in order; a word is visible 3 cycles after its write,
   // never earlier than the cycle after its predecessor popped. Words not yet
   // visible at the output occupy RAM slots, and 4 of those means full.
   typedef struct {
      logic [127:0] d;
      int           w;
   } ent_t;
   ent_t q[$];

   initial begin
      int  last_pop = -100;
      int  wcnt = 0;
      bit  rst_prev = 1'b1;
      bit  exp_pvld, exp_prdy, exp_we;
      int  avail, in_ram;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_wr_prdy", wr_prdy, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_ram_re", ram_re, 0);
            chk("rst_ram_ore", ram_ore, 0);
            if (rst_prev) begin
               chk("rst_rd_pvld", rd_pvld, 0);
               chk("rst_ram_wa", ram_wa, 0);
               chk("rst_ram_ra", ram_ra, 0);
`ifdef NV_FIFO_CTRL_CNT_EN
               chk("rst_fifo_cnt", fifo_cnt, 0);
`endif
            end
            q.delete();
            last_pop = -100;
            wcnt = 0;
         end else begin
            exp_pvld = 1'b0;
            if (q.size() > 0) begin
               avail = (q[0].w + 3 > last_pop + 1) ? q[0].w + 3 : last_pop + 1;
               exp_pvld = (cyc >= avail);
            end
            in_ram   = q.size() - (exp_pvld ? 1 : 0);
            exp_prdy = (in_ram < 4);
            exp_we   = wr_pvld && exp_prdy;
            chk("m_rd_pvld", rd_pvld, exp_pvld);
            chk("m_wr_prdy", wr_prdy, exp_prdy);
            chk("m_ram_we", ram_we, exp_we);
            chk("m_ram_wa", ram_wa, wcnt % 4);
            if (exp_pvld) chk("m_rd_pd", rd_pd, q[0].d);
`ifdef NV_FIFO_CTRL_CNT_EN
            chk("m_fifo_cnt", fifo_cnt, q.size());
`endif
            if (exp_pvld && rd_prdy) begin
               void'(q.pop_front());
               last_pop = cyc;
            end
            if (exp_we) begin
               q.push_back('{wr_pd, cyc});
               wcnt++;
            end
         end
         rst_prev = rst;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      #3;
   endtask

   initial begin
      logic [127:0] a5;
      logic [4:0]   seen;
      logic [127:0] got;
      int           acc, sent, rcv, budget;
      bit           saw3, wrap;
      bit           found;

      a5 = {16{8'hA5}};
      rst = 1'b1; wr_pvld = 1'b1; rd_prdy = 1'b0; wr_pd = '0;

      // Reset held 2 cycles with a write pending.
      step(); step();
      rst = 1'b0; wr_pvld = 1'b0;
      sample();
      chk("rel_wr_prdy", wr_prdy, 1);
      step();

      // Single word: visible exactly in cycle 3 for one cycle.
      rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = a5;
      step();
      wr_pvld = 1'b0; wr_pd = '0;
      seen = '0; got = '0;
      for (int k = 1; k <= 5; k++) begin
         sample();
         seen[k-1] = rd_pvld;
         if (k == 3) got = rd_pd;
         step();
      end
      chk("single_pvld_mask", seen, 5'b00100);
      chk("single_data", got, a5);

      // Fill: 6 offered with downstream stalled, 5 taken.
      rd_prdy = 1'b0; wr_pvld = 1'b1; acc = 0;
      for (int i = 1; i <= 6; i++) begin
         wr_pd = 128'(i);
         sample();
         if (ram_we) acc++;
         step();
      end
      wr_pvld = 1'b0;
      chk("fill_accepted", acc, 5);
      for (int k = 0; k < 3; k++) begin
         sample();
         chk("fill_wr_prdy", wr_prdy, 0);
         chk("fill_pvld", rd_pvld, 1);
         chk("fill_rd_pd", rd_pd, 1);
`ifdef NV_FIFO_CTRL_CNT_EN
         chk("fill_cnt", fifo_cnt, 5);
`endif
         step();
      end

      // Drain: consecutive pops 1..5, wr_prdy back one cycle after the first pop.
      rd_prdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         sample();
         chk("drain_pvld", rd_pvld, 1);
         chk("drain_data", rd_pd, 128'(k + 1));
         if (k == 0) chk("drain_prdy0", wr_prdy, 0);
         if (k == 1) chk("drain_prdy1", wr_prdy, 1);
         step();
      end
      sample();
      chk("drain_empty", rd_pvld, 0);
      step();

      // Streaming: 100 words, random backpressure, covering pointer wrap.
      sent = 0; rcv = 0; saw3 = 1'b0; wrap = 1'b0; budget = 0;
      while (rcv < 100 && budget < 3000) begin
         wr_pvld = (sent < 100);
         wr_pd   = 128'(1000 + sent);
         rd_prdy = 1'($urandom_range(0, 1));
         sample();
         if (ram_we) begin
            if (ram_wa == 2'd3) saw3 = 1'b1;
            else if (ram_wa == 2'd0 && saw3) wrap = 1'b1;
            sent++;
         end
         if (rd_pvld && rd_prdy) begin
            chk("stream_data", rd_pd, 128'(1000 + rcv));
            rcv++;
         end
         step();
         budget++;
      end
      wr_pvld = 1'b0; rd_prdy = 1'b0;
      chk("stream_count", rcv, 100);
      chk("stream_wrap", wrap, 1);
      step();

      // Mid reset with 3 words in flight.
      wr_pvld = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_pd = 128'(8'h11 * (i + 1));
         step();
      end
      wr_pvld = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sample();
         chk("mid_empty_pvld", rd_pvld, 0);
         chk("mid_wr_prdy", wr_prdy, 1);
         step();
      end
      wr_pvld = 1'b1; wr_pd = 128'h77; rd_prdy = 1'b1;
      step();
      wr_pvld = 1'b0; wr_pd = '0;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         sample();
         if (rd_pvld) begin
            found = 1'b1;
            chk("mid_next_word", rd_pd, 128'h77);
         end
         step();
      end
      chk("mid_found", found, 1);
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/nv_fifo_ctrl_4x128.md
# nv_fifo_ctrl_4x128

Valid/ready FIFO controller that drives the 4-entry x 128-bit two-port RAM (1-cycle registered read address, 1-cycle registered output enable) and turns it into a 5-deep streaming FIFO. The controller sits directly upstream of the RAM. It generates write and read addresses and enables, and tracks the 2-stage read pipeline so `rd_pvld` aligns with RAM `dout`. It is instantiated beside the RAM in every NVDLA buffering point that uses this macro.

## Interface
Parameters:
- `DEPTH`, 4: RAM entries; fixed, must match the RAM.
- `AW`, 2: RAM address width.
- `DW`, 128: payload width.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `wr_pvld`  in  1  upstream data valid.
- `wr_prdy`  out  1  controller can accept a write.
- `wr_pd`  in  DW  upstream payload.
- `rd_pvld`  out  1  downstream data valid.
- `rd_prdy`  in  1  downstream accepts.
- `rd_pd`  out  DW  downstream payload; passthrough of `ram_dout`.
- `ram_we`  out  1  RAM write enable.
- `ram_wa`  out  AW  RAM write address.
- `ram_di`  out  DW  RAM write data; passthrough of `wr_pd`.
- `ram_re`  out  1  RAM read-address register enable.
- `ram_ra`  out  AW  RAM read address.
- `ram_ore`  out  1  RAM output register enable.
- `ram_dout`  in  DW  RAM registered output.
- `fifo_cnt`  out  3  occupancy; present only with `NV_FIFO_CTRL_CNT_EN`.

## Operation
State:
- `wptr`, `rptr`: AW-bit pointers, wrap modulo 4.
- `ram_cnt`: 0..4, entries written but not yet captured into the RAM output register.
- `unrd_cnt`: 0..4, entries written but not yet issued with `ram_re`.
- `s1_vld`: RAM `ra_d` holds a live address.
- `s2_vld`: RAM `dout_r` holds live data.

Write side:
- `wr_prdy = !rst && (ram_cnt != 4)`.
- `ram_we = wr_pvld && wr_prdy`. `ram_wa = wptr`. `wptr` increments on `ram_we`.

Read pipeline:
- `rd_pvld = s2_vld`.
- `pop = s2_vld && rd_prdy`.
- `ram_ore = !rst && s1_vld && (!s2_vld || pop)`.
- `ram_re = !rst && (unrd_cnt != 0) && (!s1_vld || ram_ore)`.
- `ram_ra = rptr`. `rptr` increments on `ram_re`.

Register updates:
- `s1_vld` becomes `ram_re`. It stays set if held.
- `s2_vld` becomes `ram_ore || (s2_vld && !pop)`.
- `ram_cnt` changes by +`ram_we` −`ram_ore`. Simultaneous events leave it unchanged.
- `unrd_cnt` changes by +`ram_we` −`ram_re`.

Hazard rules:
- The RAM slot is freed on `ram_ore`. `wr_prdy` uses the registered `ram_cnt`, so a write can never target `ra_d` in the same cycle its data is captured.
- Full means `ram_cnt == 4`. Total capacity is 5 (4 in RAM plus 1 in `dout_r`).
- Empty means `unrd_cnt == 0 && !s1_vld && !s2_vld`.

Reset:
- All pointers, counts and valids are cleared to 0.
- Reset outputs: `wr_prdy=0`, `rd_pvld=0`, `ram_we=0`, `ram_re=0`, `ram_ore=0`, `ram_wa=0`, `ram_ra=0`, `fifo_cnt=0`.
- Reset mid-operation discards all in-flight data. RAM contents are untouched but unreachable.

## Timing
- Write-to-read latency: a write accepted at edge t gives `ram_re` in cycle t+1 and `ram_ore` in t+2. `rd_pvld` is high in t+3.
- Sustained throughput is 1 transfer/cycle with `rd_prdy` held high.
- With `rd_prdy` low, `dout_r`, `ra_d` and `rd_pd` hold stable. `rd_pvld` never drops without a pop.
- `wr_prdy` returns in the cycle after the first `ram_ore` that relieves full.

## Configuration
- `NV_FIFO_CTRL_CNT_EN` defined:
  - `fifo_cnt` port exists.
  - Its value is the registered sum `ram_cnt + s2_vld`, range 0..5, updated each edge.
- Not defined:
  - Port and logic are absent.
  - Behaviour is otherwise identical.

## Structure
- The shared package holds `NV_FIFO_DEPTH=4`, `NV_FIFO_AW=2`, `NV_FIFO_DW=128` and the 3-bit count typedef.
- One sub-module is natural: `nv_fifo_rd_pipe`. It contains `s1_vld`, `s2_vld`, the `ore`/`re` gating and `pop`.
- The top keeps pointers and counts.
- The bench top instantiates this block plus `nv_ram_rwsp_4x128`.

## Test plan
- Reset:
  - Stimulus: assert `rst` 2 cycles, with `wr_pvld=1`.
  - Required: `ram_we=0`, `wr_prdy=0`, `rd_pvld=0`.
  - Required: `wr_prdy=1` in the first cycle after release.
- Single word:
  - Stimulus: write `128'hA5…` at cycle 0, with `rd_prdy=1`.
  - Required: `rd_pvld` high exactly in cycle 3, with matching data, for 1 cycle.
- Fill:
  - Stimulus: 6 back-to-back writes of 1..6 with `rd_prdy=0`.
  - Required: exactly 5 are accepted and `wr_prdy` goes low.
  - Required: `fifo_cnt=5`, `rd_pd=1` held stable.
- Drain:
  - Stimulus: from full, `rd_prdy=1`.
  - Required: pops 1..5 on consecutive cycles.
  - Required: `wr_prdy` re-rises one cycle after the first pop.
- Streaming:
  - Stimulus: 100 words with `wr_pvld=1` and random `rd_prdy`.
  - Required: in-order, lossless, with pointer wrap at address 3→0 covered.
- Mid reset:
  - Stimulus: assert `rst` with 3 entries in flight.
  - Required: empty afterwards; the next write of `0x77` is the next word out.
